attn_residual_stream: RTL and testbench
=======================================

ATTN_RESIDUAL_STREAM -- requirements
Module: attn_residual_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed element width of every token element.
REQ-002 SHALL have parameter SEQ_LEN, default 64, number of tokens.
REQ-003 SHALL have parameter EMBED_DIM, default 64, elements per token.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin streaming, issued when the attention stage raises done.
REQ-007 SHALL have port attn_flat  input  DATA_WIDTH*SEQ_LEN*EMBED_DIM  attention output tokens; element e at bits [e*DATA_WIDTH +: DATA_WIDTH], e = token*EMBED_DIM + dim.
REQ-008 SHALL have port resid_flat  input  DATA_WIDTH*SEQ_LEN*EMBED_DIM  original input tokens, same packing.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-010 SHALL have port out_ready  input  1  downstream accepts element when high with out_valid.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  signed residual sum of current element.
REQ-012 SHALL have port out_token  output  $clog2(SEQ_LEN) (min 1)  token index of out_data.
REQ-013 SHALL have port out_dim  output  $clog2(EMBED_DIM) (min 1)  dim index of out_data.
REQ-014 SHALL have port out_last  output  1  high with out_valid on final element (SEQ_LEN-1, EMBED_DIM-1).
REQ-015 SHALL have port busy  output  1  high in STREAM.
REQ-016 SHALL have port done  output  1  one-cycle pulse after final element transferred.
REQ-017 SHALL have port sat_count  output  $clog2(SEQ_LEN*EMBED_DIM+1)  number of saturated elements transferred in current/last run.

Function
REQ-018 SHALL implement states IDLE, STREAM, FINISH.
REQ-019 IDLE: start=1 SHALL move to STREAM next edge, load element 0 (token 0, dim 0) into out_data/out_token/out_dim, set out_valid=1, clear sat_count.
REQ-020 Latency: out_valid SHALL rise exactly one cycle after the accepted start cycle.
REQ-021 STREAM: a transfer occurs on an edge where out_valid&&out_ready; SHALL then load next element (dim increments; dim wraps EMBED_DIM-1 -> 0 with token+1).
REQ-022 While out_valid=1 and out_ready=0, out_data, out_token, out_dim, out_last SHALL hold unchanged.
REQ-023 out_data SHALL equal attn element + resid element computed in DATA_WIDTH+1 bits, saturated to signed DATA_WIDTH range: >2^(W-1)-1 -> 2^(W-1)-1, < -2^(W-1) -> -2^(W-1).
REQ-024 sat_count SHALL increment by 1 on each transfer of an element whose sum saturated; no wrap (max SEQ_LEN*EMBED_DIM).
REQ-025 Transfer of the out_last element SHALL go to FINISH with out_valid=0, out_last=0.
REQ-026 FINISH SHALL assert done=1 for exactly one cycle then return to IDLE; done=0 in all other states.
REQ-027 start while in STREAM or FINISH SHALL be ignored (no restart, no counter clear).
REQ-028 start in the same cycle as FINISH->IDLE SHALL be ignored; a new start is accepted only in IDLE.
REQ-029 attn_flat and resid_flat SHALL be sampled per element at load time; upstream holds them stable from start to done.
REQ-030 sat_count SHALL retain its value in IDLE until the next accepted start.
REQ-031 SEQ_LEN=1, EMBED_DIM=1 SHALL work: element 0 has out_last=1 at first out_valid.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, out_valid=0, out_last=0, busy=0, done=0, out_data=0, out_token=0, out_dim=0, sat_count=0, regardless of clk.
REQ-033 Reset asserted mid-STREAM SHALL abort the run with no done pulse; after release the block waits for a fresh start.

Verification (DATA_WIDTH=8, SEQ_LEN=2, EMBED_DIM=2)
REQ-034 attn={1,2,3,4}, resid={10,20,30,40}, out_ready=1, start pulse -> out_valid next cycle, out_data 11,22,33,44 on 4 consecutive cycles, indices (0,0),(0,1),(1,0),(1,1), out_last on 4th, done 1 cycle later, sat_count=0.
REQ-035 attn element0=100, resid element0=100; element1 = -100 + -100 -> out_data 127 then -128, sat_count=2 at done.
REQ-036 out_ready toggling 1,0,0,1,... -> each element held while out_ready=0, no element skipped or repeated, exactly 4 transfers, single done pulse.
REQ-037 start pulsed again during STREAM and on done cycle -> ignored, stream completes unchanged; start in following IDLE cycle begins new run with sat_count cleared.
REQ-038 rst_n driven low after second transfer, between clock edges -> outputs zero immediately, no done; release then start -> full 4-element run from (0,0).

Source files
------------

// File: rtl/attn_residual_stream.sv
// Streams attention output plus residual, one saturated element per handshake.
// Runs IDLE -> STREAM -> FINISH with a one-cycle done pulse.
module attn_residual_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_LEN    = 64,
    parameter int EMBED_DIM  = 64,
    localparam int TW  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    localparam int DW  = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1,
    localparam int NE  = SEQ_LEN * EMBED_DIM,
    localparam int SCW = $clog2(NE + 1),
    localparam int FW  = DATA_WIDTH * NE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [FW-1:0]                attn_flat,
    input  logic [FW-1:0]                resid_flat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [TW-1:0]                out_token,
    output logic [DW-1:0]                out_dim,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic [SCW-1:0]               sat_count
);

    localparam int IW = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t                 state_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   sat_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [TW-1:0]          tok_q;
    logic [DW-1:0]          dim_q;
    logic [SCW-1:0]         sat_cnt_q;

    logic [TW-1:0]          ld_tok_d;
    logic [DW-1:0]          ld_dim_d;
    logic [DATA_WIDTH-1:0]  ld_a;
    logic [DATA_WIDTH-1:0]  ld_b;
    logic [DATA_WIDTH:0]    sum_d;
    logic [DATA_WIDTH-1:0]  ld_data_d;
    logic                   ld_sat_d;
    logic                   ld_last_d;
    int                     ld_idx;

    // Index of the element to load next: (0,0) from IDLE, else successor.
    always_comb begin
        ld_tok_d = '0;
        ld_dim_d = '0;
        if (state_q == STREAM && !last_q) begin
            if (dim_q == DW'(EMBED_DIM - 1)) begin
                ld_tok_d = tok_q + 1'b1;
            end else begin
                ld_tok_d = tok_q;
                ld_dim_d = dim_q + 1'b1;
            end
        end
    end

    always_comb begin
        ld_idx    = int'(ld_tok_d) * EMBED_DIM + int'(ld_dim_d);
        ld_a      = attn_flat[IW'(ld_idx * DATA_WIDTH) +: DATA_WIDTH];
        ld_b      = resid_flat[IW'(ld_idx * DATA_WIDTH) +: DATA_WIDTH];
        sum_d     = {ld_a[DATA_WIDTH-1], ld_a} + {ld_b[DATA_WIDTH-1], ld_b};
        ld_sat_d  = sum_d[DATA_WIDTH] ^ sum_d[DATA_WIDTH-1];
        ld_data_d = sum_d[DATA_WIDTH-1:0];
        if (ld_sat_d) begin
            ld_data_d = sum_d[DATA_WIDTH] ? SMIN : SMAX;
        end
        ld_last_d = (ld_tok_d == TW'(SEQ_LEN - 1)) &&
                    (ld_dim_d == DW'(EMBED_DIM - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            data_q    <= '0;
            tok_q     <= '0;
            dim_q     <= '0;
            sat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= STREAM;
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b1;
                        sat_cnt_q <= '0;
                        tok_q     <= ld_tok_d;
                        dim_q     <= ld_dim_d;
                        data_q    <= ld_data_d;
                        sat_q     <= ld_sat_d;
                        last_q    <= ld_last_d;
                    end
                end
                STREAM: begin
                    if (valid_q && out_ready) begin
                        // The counter saturates at the element count.
                        if (sat_q && sat_cnt_q != SCW'(NE)) begin
                            sat_cnt_q <= sat_cnt_q + 1'b1;
                        end
                        if (last_q) begin
                            state_q <= FINISH;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            tok_q  <= ld_tok_d;
                            dim_q  <= ld_dim_d;
                            data_q <= ld_data_d;
                            sat_q  <= ld_sat_d;
                            last_q <= ld_last_d;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_token = tok_q;
    assign out_dim   = dim_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_attn_residual_stream.sv
// Directed bench for attn_residual_stream with W=8, 2 tokens x 2 dims.
module tb_attn_residual_stream;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [31:0]        attn_flat;
    logic [31:0]        resid_flat;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic [0:0]         out_token;
    logic [0:0]         out_dim;
    logic               out_last;
    logic               busy;
    logic               done;
    logic [2:0]         sat_count;

    int checks = 0;
    int errors = 0;
    logic signed [7:0] exp_d [4];

    attn_residual_stream #(
        .DATA_WIDTH(8),
        .SEQ_LEN(2),
        .EMBED_DIM(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .attn_flat(attn_flat),
        .resid_flat(resid_flat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_token(out_token),
        .out_dim(out_dim),
        .out_last(out_last),
        .busy(busy),
        .done(done),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One run from IDLE; pat gives out_ready per cycle (bit c%4).
    task automatic stream_run(input logic [3:0] pat, input int exp_sat);
        int idx;
        int dones;
        idx   = 0;
        dones = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("latency_valid", 32'(out_valid), 1);
        for (int c = 0; c < 16 && dones == 0; c++) begin
            if (out_valid) begin
                chk("data", out_data, exp_d[idx]);
                chk("token", 32'(out_token), idx / 2);
                chk("dim", 32'(out_dim), idx % 2);
                chk("last", 32'(out_last), (idx == 3) ? 1 : 0);
                chk("busy", 32'(busy), 1);
            end
            if (done) begin
                dones++;
                chk("fin_valid", 32'(out_valid), 0);
                chk("fin_last", 32'(out_last), 0);
            end
            out_ready = pat[c % 4];
            if (out_valid && out_ready) idx++;
            @(negedge clk);
        end
        chk("transfers", idx, 4);
        chk("done_pulses", dones, 1);
        chk("done_drop", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("sat_count", 32'(sat_count), exp_sat);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b1;
        attn_flat  = 32'h04030201;
        resid_flat = 32'h281E140A;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", 32'(sat_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_d = '{8'sd11, 8'sd22, 8'sd33, 8'sd44};
        stream_run(4'b1111, 0);

        attn_flat  = 32'hFD059C64;
        resid_flat = 32'h07069C64;
        exp_d = '{8'sd127, -8'sd128, 8'sd11, 8'sd4};
        stream_run(4'b1001, 2);
        @(negedge clk);
        chk("sat_retained", 32'(sat_count), 2);

        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("r3_e0", out_data, 127);
        @(negedge clk);
        chk("r3_sat1", 32'(sat_count), 1);
        @(negedge clk);
        start = 1'b1;
        chk("r3_e2", out_data, 11);
        chk("r3_sat2", 32'(sat_count), 2);
        @(negedge clk);
        start = 1'b0;
        chk("r3_e3", out_data, 4);
        chk("r3_last", 32'(out_last), 1);
        chk("r3_sat_hold", 32'(sat_count), 2);
        @(negedge clk);
        chk("r3_done", 32'(done), 1);
        chk("r3_sat_done", 32'(sat_count), 2);
        start = 1'b1;
        @(negedge clk);
        chk("r3_ign_valid", 32'(out_valid), 0);
        chk("r3_ign_done", 32'(done), 0);
        chk("r3_ign_busy", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        chk("r3_new_valid", 32'(out_valid), 1);
        chk("r3_new_data", out_data, 127);
        chk("r3_new_sat", 32'(sat_count), 0);
        chk("r3_new_tok", 32'(out_token), 0);
        for (int c = 0; c < 10 && !done; c++) @(negedge clk);
        chk("r3_fin_done", 32'(done), 1);
        chk("r3_fin_sat", 32'(sat_count), 2);
        @(negedge clk);

        attn_flat  = 32'h04030201;
        resid_flat = 32'h281E140A;
        exp_d = '{8'sd11, 8'sd22, 8'sd33, 8'sd44};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_e2", out_data, 33);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_data", out_data, 0);
        chk("mid_tok", 32'(out_token), 0);
        chk("mid_dim", 32'(out_dim), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_sat", 32'(sat_count), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_idle_valid", 32'(out_valid), 0);
        chk("post_idle_done", 32'(done), 0);
        stream_run(4'b1111, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
